// File: rtl/seq_shift_add_mult.sv
// Iterative shift-add multiplier, one partial product per clock.
// Define MULT_SIGNED_EN for two's complement operands/product.
module seq_shift_add_mult #(
  parameter int D_SIZE = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic [D_SIZE-1:0]     A,
  input  logic [D_SIZE-1:0]     B,
  output logic                  busy,
  output logic                  done,
  output logic [2*D_SIZE-1:0]   P
);

  localparam int CW = (D_SIZE > 2) ? $clog2(D_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(D_SIZE - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

  logic [1:0]          r_state;
  logic [D_SIZE-1:0]   r_mcand;
  logic [D_SIZE-1:0]   r_mplr;
  logic [D_SIZE-1:0]   r_acc;
  logic [CW-1:0]       r_cnt;
  logic                r_done;
  logic [2*D_SIZE-1:0] r_p;

  logic                w_ready;
  logic                w_start;
  logic [D_SIZE:0]     w_sum;
  logic [2*D_SIZE-1:0] w_prod;
  logic [D_SIZE-1:0]   w_op_a;
  logic [D_SIZE-1:0]   w_op_b;
  logic [2*D_SIZE-1:0] w_res;

  assign w_ready = (r_state == S_IDLE) || (r_state == S_FIN);
  assign w_start = start_in && w_ready;
  assign w_sum   = {1'b0, r_acc}
                 + (r_mplr[0] ? {1'b0, r_mcand} : '0);
  assign w_prod  = {r_acc, r_mplr};

`ifdef MULT_SIGNED_EN
  logic r_neg;

  // Magnitudes feed the unsigned core; sign is restored at the end.
  assign w_op_a = A[D_SIZE-1] ? D_SIZE'(-A) : A;
  assign w_op_b = B[D_SIZE-1] ? D_SIZE'(-B) : B;
  assign w_res  = r_neg ? (2*D_SIZE)'(-w_prod) : w_prod;

  // Sign of the product, captured with the operands.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_neg <= 1'b0;
    end else if (w_start) begin
      r_neg <= A[D_SIZE-1] ^ B[D_SIZE-1];
    end
  end
`else
  assign w_op_a = A;
  assign w_op_b = B;
  assign w_res  = w_prod;
`endif

  // Control FSM and shift-add datapath.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= S_IDLE;
      r_mcand <= '0;
      r_mplr  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      r_p     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_RUN: begin
          r_acc  <= w_sum[D_SIZE:1];
          r_mplr <= {w_sum[0], r_mplr[D_SIZE-1:1]};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == LAST) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_p     <= w_res;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_start) begin
        r_mcand <= w_op_a;
        r_mplr  <= w_op_b;
        r_acc   <= '0;
        r_cnt   <= '0;
        r_state <= S_RUN;
      end
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = r_done;
  assign P    = r_p;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
// Bench for seq_shift_add_mult (D_SIZE=8).
// Signed vectors are used when MULT_SIGNED_EN is defined.
module tb_seq_shift_add_mult;

  localparam int D = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [D-1:0]  a = '0;
  logic [D-1:0]  b = '0;
  logic          busy;
  logic          done;
  logic [2*D-1:0] p;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    logic [D-1:0]   a;
    logic [D-1:0]   b;
    logic [2*D-1:0] p;
  } vec_t;

  typedef struct {
    logic [2*D-1:0] p;
    int             cyc;
  } exp_t;

  exp_t sbq[$];
  vec_t tbl[8];

  seq_shift_add_mult #(.D_SIZE(D)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .start_in (start),
    .A        (a),
    .B        (b),
    .busy     (busy),
    .done     (done),
    .P        (p)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Scoreboard: every done must match the oldest expected result.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexp_done: act=done exp=none P=%h", p);
      end else begin
        e = sbq.pop_front();
        check("P", 32'(p), 32'(e.p));
        check("latency", 32'(cyc - e.cyc), 32'(D + 1));
      end
    end
  end

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (!done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: act=no_done exp=done", nm);
    end
  endtask

  task automatic run_op(input logic [D-1:0] ia,
                        input logic [D-1:0] ib,
                        input logic [2*D-1:0] ep);
    exp_t e;
    @(negedge clk);
    a = ia;
    b = ib;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.p = ep;
    e.cyc = cyc;
    sbq.push_back(e);
    check("busy_run", 32'(busy), 32'd1);
    wait_done("op");
    @(negedge clk);
    check("busy_after", 32'(busy), 32'd0);
    check("done_pulse", 32'(done), 32'd0);
  endtask

  initial begin
    exp_t e;
`ifdef MULT_SIGNED_EN
    tbl[0] = '{8'h80, 8'h80, 16'h4000};
    tbl[1] = '{8'hFD, 8'h05, 16'hFFF1};
    tbl[2] = '{8'h7F, 8'hFF, 16'hFF81};
    tbl[3] = '{8'h0D, 8'h0B, 16'h008F};
    tbl[4] = '{8'hFF, 8'hFF, 16'h0001};
    tbl[5] = '{8'h00, 8'h9C, 16'h0000};
    tbl[6] = '{8'h7F, 8'h7F, 16'h3F01};
    tbl[7] = '{8'h80, 8'h01, 16'hFF80};
`else
    tbl[0] = '{8'd13,  8'd11,  16'h008F};
    tbl[1] = '{8'd255, 8'd255, 16'hFE01};
    tbl[2] = '{8'd0,   8'd200, 16'h0000};
    tbl[3] = '{8'd200, 8'd0,   16'h0000};
    tbl[4] = '{8'd1,   8'd1,   16'h0001};
    tbl[5] = '{8'd128, 8'd2,   16'h0100};
    tbl[6] = '{8'd7,   8'd6,   16'h002A};
    tbl[7] = '{8'd100, 8'd100, 16'h2710};
`endif

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_P", 32'(p), 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].p);
    end

`ifndef MULT_SIGNED_EN
    // Start while busy is ignored.
    @(negedge clk);
    a = 8'd7;
    b = 8'd6;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    e.p = 16'd42;
    e.cyc = cyc;
    sbq.push_back(e);
    repeat (2) @(negedge clk);
    a = 8'd9;
    b = 8'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ign");
    repeat (14) @(negedge clk);
    check("ign_q", 32'(sbq.size()), 32'd0);

    // Back-to-back: start held through FIN.
    @(negedge clk);
    a = 8'd5;
    b = 8'd5;
    start = 1'b1;
    @(negedge clk);
    e.p = 16'd25;
    e.cyc = cyc;
    sbq.push_back(e);
    a = 8'd3;
    b = 8'd4;
    wait_done("b2b1");
    e.p = 16'd12;
    e.cyc = cyc;
    sbq.push_back(e);
    start = 1'b0;
    check("b2b_busy", 32'(busy), 32'd1);
    @(negedge clk);
    wait_done("b2b2");
    @(negedge clk);
    check("b2b_q", 32'(sbq.size()), 32'd0);

    // Reset in the middle of a run.
    @(negedge clk);
    a = 8'd100;
    b = 8'd100;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_P", 32'(p), 32'd0);
    repeat (12) @(negedge clk);
    check("abort_P2", 32'(p), 32'd0);
    run_op(8'd5, 8'd5, 16'd25);
`endif

    repeat (3) @(negedge clk);
    check("final_q", 32'(sbq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
